// File: rtl/led_bcm_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// led_bcm_scheduler : HUB75 row/bit-plane BCM scanout scheduler with overlapped
// column shifting. Optional duty scaling: `LED_BCM_BRIGHTNESS_EN.  Rev 1.0
//==============================================================================
module led_bcm_scheduler #(
   parameter int ADDR_BITS  = 5,
   parameter int PLANES     = 4,
   parameter int BASE_TICKS = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic [7:0]           brightness,
   output logic                 shift_start,
   output logic [ADDR_BITS-1:0] shift_row,
   output logic [2:0]           shift_plane,
   input  logic                 shift_done,
   output logic [ADDR_BITS-1:0] led_addr,
   output logic                 led_latch,
   output logic                 led_blank,
   output logic                 frame_start
);

   localparam int TW = $clog2(BASE_TICKS << (PLANES - 1)) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SHIFT = 3'd1;
   localparam logic [2:0] S_BLANK = 3'd2;
   localparam logic [2:0] S_LATCH = 3'd3;
   localparam logic [2:0] S_SHOW  = 3'd4;

   logic [2:0]           state_q, state_d;
   logic                 start_q, start_d;
   logic [ADDR_BITS-1:0] row_q, row_d;
   logic [2:0]           plane_q, plane_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 latch_q, latch_d;
   logic                 blank_q, blank_d;
   logic                 frame_q, frame_d;
   logic                 pending_q, pending_d;
   logic                 outst_q, outst_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [TW-1:0]        load_q, load_d;
   logic [TW-1:0]        off_q, off_d;

   logic [TW-1:0]        slot_load;
   logic [TW-1:0]        off_calc;
   logic                 done_acc;
   logic                 last_plane;

   assign slot_load  = TW'(BASE_TICKS) << plane_q;
   assign done_acc   = shift_done & outst_q;
   assign last_plane = (plane_q == 3'(PLANES - 1));

`ifdef LED_BCM_BRIGHTNESS_EN
   logic [TW+7:0] lit_prod;
   assign lit_prod = (TW+8)'(slot_load) * (TW+8)'(brightness);
   assign off_calc = slot_load - lit_prod[TW+7:8];
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign off_calc = '0;
`endif

   always_comb begin
      state_d   = state_q;
      start_d   = 1'b0;
      row_d     = row_q;
      plane_d   = plane_q;
      addr_d    = addr_q;
      latch_d   = 1'b0;
      frame_d   = 1'b0;
      pending_d = pending_q;
      outst_d   = outst_q & ~shift_done;
      timer_d   = timer_q;
      load_d    = load_q;
      off_d     = off_q;

      case (state_q)
         S_IDLE: begin
            pending_d = 1'b0;
            outst_d   = 1'b0;
            if (enable) begin
               start_d = 1'b1;
               row_d   = '0;
               plane_d = '0;
               outst_d = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (done_acc) state_d = S_BLANK;
         end
         S_BLANK: begin
            latch_d = 1'b1;
            addr_d  = row_q;
            frame_d = (row_q == '0) && (plane_q == '0);
            load_d  = slot_load;
            off_d   = off_calc;
            state_d = S_LATCH;
         end
         S_LATCH: begin
            // Shift of the next slot overlaps this slot's on-time.
            timer_d = load_q;
            state_d = S_SHOW;
            if (enable) begin
               start_d = 1'b1;
               outst_d = 1'b1;
               if (last_plane) begin
                  plane_d = '0;
                  row_d   = row_q + 1'b1;
               end else begin
                  plane_d = plane_q + 3'd1;
               end
            end
         end
         S_SHOW: begin
            if (done_acc) pending_d = 1'b1;
            timer_d = timer_q - 1'b1;
            if (timer_q == TW'(1)) begin
               if (!enable) begin
                  pending_d = 1'b0;
                  outst_d   = 1'b0;
                  state_d   = S_IDLE;
               end else if (pending_q || done_acc) begin
                  pending_d = 1'b0;
                  state_d   = S_BLANK;
               end else if (outst_q) begin
                  state_d = S_SHIFT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // timer_d counts remaining on-time cycles including the coming one.
      blank_d = !((state_d == S_SHOW) && (timer_d > off_d));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         start_q   <= 1'b0;
         row_q     <= '0;
         plane_q   <= '0;
         addr_q    <= '0;
         latch_q   <= 1'b0;
         blank_q   <= 1'b1;
         frame_q   <= 1'b0;
         pending_q <= 1'b0;
         outst_q   <= 1'b0;
         timer_q   <= '0;
         load_q    <= '0;
         off_q     <= '0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         row_q     <= row_d;
         plane_q   <= plane_d;
         addr_q    <= addr_d;
         latch_q   <= latch_d;
         blank_q   <= blank_d;
         frame_q   <= frame_d;
         pending_q <= pending_d;
         outst_q   <= outst_d;
         timer_q   <= timer_d;
         load_q    <= load_d;
         off_q     <= off_d;
      end
   end

   assign shift_start = start_q;
   assign shift_row   = row_q;
   assign shift_plane = plane_q;
   assign led_addr    = addr_q;
   assign led_latch   = latch_q;
   assign led_blank   = blank_q;
   assign frame_start = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_led_bcm_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// tb_led_bcm_scheduler : scoreboard bench with a modelled column shifter.
//==============================================================================
module tb_led_bcm_scheduler;

   localparam int AB = 5;
   localparam int PL = 4;
   localparam int BT = 32;

   logic          clk;
   logic          resetn;
   logic          enable;
   logic [7:0]    brightness;
   logic          shift_start;
   logic [AB-1:0] shift_row;
   logic [2:0]    shift_plane;
   logic          shift_done;
   logic [AB-1:0] led_addr;
   logic          led_latch;
   logic          led_blank;
   logic          frame_start;
   logic          resp_done;
   logic          spur_done;

   assign shift_done = resp_done | spur_done;

   led_bcm_scheduler #(
      .ADDR_BITS (AB),
      .PLANES    (PL),
      .BASE_TICKS(BT)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .enable     (enable),
      .brightness (brightness),
      .shift_start(shift_start),
      .shift_row  (shift_row),
      .shift_plane(shift_plane),
      .shift_done (shift_done),
      .led_addr   (led_addr),
      .led_latch  (led_latch),
      .led_blank  (led_blank),
      .frame_start(frame_start)
   );

   typedef struct {
      int row;
      int plane;
   } slot_t;

   slot_t exp_q[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    done_delay = 5;
   bit    coin = 0, slow_chk = 0, lat_chk = 0, period_chk = 0;
   int    restart_cnt = 0;
   int    latch_cnt = 0, frame_cnt = 0, start_cnt = 0;
   int    done_cyc = 0, last_latch_cyc = 0;
   int    lat_row = -1, lat_plane = -1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever @(posedge clk) cyc++;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Expected lit cycles of a plane at the brightness in force when it latches.
   function automatic int lit_exp(input int p);
      int t;
      t = BT << p;
`ifdef LED_BCM_BRIGHTNESS_EN
      return (t * int'(brightness)) >> 8;
`else
      return t;
`endif
   endfunction

   // Column shifter model: checks the commanded slot, answers with shift_done.
   initial begin
      int m_row, m_plane, seen_restart, d, r, p;
      bit aborted;
      m_row = 0; m_plane = 0; seen_restart = 0;
      resp_done = 1'b0;
      forever begin
         @(negedge clk);
         if (resetn && shift_start) begin
            if (seen_restart != restart_cnt) begin
               seen_restart = restart_cnt;
               m_row = 0; m_plane = 0;
               exp_q.delete();
            end
            start_cnt++;
            check("shift_row", int'(shift_row), m_row);
            check("shift_plane", int'(shift_plane), m_plane);
            r = m_row; p = m_plane;
            m_plane++;
            if (m_plane == PL) begin
               m_plane = 0;
               m_row   = (m_row + 1) % (1 << AB);
            end
            if (coin) d = (BT << ((p + PL - 1) % PL)) - 1;
            else      d = done_delay;
            aborted = 1'b0;
            for (int i = 0; i < d && !aborted; i++) begin
               @(negedge clk);
               if (!resetn) aborted = 1'b1;
            end
            if (!aborted) begin
               if (slow_chk) check("slow_wait_blank", int'(led_blank), 1);
               resp_done = 1'b1;
               done_cyc  = cyc;
               exp_q.push_back('{row: r, plane: p});
               @(negedge clk);
               resp_done = 1'b0;
            end
         end
      end
   end

   // Panel monitor: pops the scoreboard on every latch and measures on-time.
   initial begin
      slot_t s;
      bit    active;
      int    act_plane, act_lit, lit_cnt;
      active = 1'b0; act_plane = 0; act_lit = 0; lit_cnt = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            active  = 1'b0;
            lit_cnt = 0;
         end else begin
            if (frame_start) begin
               frame_cnt++;
               check("frame_with_latch", int'(led_latch), 1);
            end
            if (led_latch) begin
               if (active) begin
                  check("lit_cycles", lit_cnt, act_lit);
                  if (period_chk) check("slot_period", cyc - last_latch_cyc, (BT << act_plane) + 2);
               end
               if (lat_chk) check("done_to_latch", cyc - done_cyc, 2);
               last_latch_cyc = cyc;
               check("latch_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  s = exp_q.pop_front();
                  check("led_addr", int'(led_addr), s.row);
                  check("frame_start", int'(frame_start), (s.row == 0 && s.plane == 0) ? 1 : 0);
                  lat_row   = s.row;
                  lat_plane = s.plane;
                  act_plane = s.plane;
                  act_lit   = lit_exp(s.plane);
                  lit_cnt   = 0;
                  active    = 1'b1;
               end else begin
                  active = 1'b0;
               end
               latch_cnt++;
            end else if (!led_blank) begin
               lit_cnt++;
            end
         end
      end
   end

   task automatic wait_latches(input int n, input int budget);
      int target, k;
      target = latch_cnt + n;
      k = 0;
      while (latch_cnt < target && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check("latches_reached", int'(latch_cnt >= target), 1);
   endtask

   task automatic wait_slot(input int r, input int p, input int budget);
      int prev, k;
      bit found;
      prev = latch_cnt; k = 0; found = 1'b0;
      while (!found && k < budget) begin
         @(negedge clk); #1;
         k++;
         if (latch_cnt != prev) begin
            prev = latch_cnt;
            if (lat_row == r && lat_plane == p) found = 1'b1;
         end
      end
      check("slot_reached", int'(found), 1);
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: time budget exceeded at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int snap_start, snap_latch;
      resetn = 1'b0; enable = 1'b0; brightness = 8'd255; spur_done = 1'b0;

      repeat (3) @(negedge clk); #1;
      check("rst_shift_start", int'(shift_start), 0);
      check("rst_shift_row", int'(shift_row), 0);
      check("rst_shift_plane", int'(shift_plane), 0);
      check("rst_led_addr", int'(led_addr), 0);
      check("rst_led_latch", int'(led_latch), 0);
      check("rst_led_blank", int'(led_blank), 1);
      check("rst_frame_start", int'(frame_start), 0);

      // Normal scan with a fast shifter over a full frame.
      enable = 1'b1; resetn = 1'b1;
      @(negedge clk); #1;
      check("first_shift_start", int'(shift_start), 1);
      period_chk = 1'b1;
      wait_latches(130, 20000);
      period_chk = 1'b0;
      check("frames_in_130_latches", frame_cnt, 2);

      // Slow shifter: block waits dark in SHIFT, latches 2 cycles after done.
      done_delay = 300; slow_chk = 1'b1; lat_chk = 1'b1;
      wait_latches(3, 1500);

      // shift_done lands exactly on the last on-time cycle.
      slow_chk = 1'b0; coin = 1'b1; period_chk = 1'b1;
      wait_latches(8, 3000);
      coin = 1'b0; lat_chk = 1'b0; period_chk = 1'b0; done_delay = 5;

      // Drop enable during (row 3, plane 2).
      wait_slot(3, 2, 20000);
      repeat (3) @(negedge clk); #1;
      enable = 1'b0;
      snap_start = start_cnt; snap_latch = latch_cnt;
      repeat (200) @(negedge clk); #1;
      check("no_start_after_disable", start_cnt - snap_start, 0);
      check("no_latch_after_disable", latch_cnt - snap_latch, 0);
      check("idle_blank", int'(led_blank), 1);
      restart_cnt++;
      enable = 1'b1;
      wait_latches(1, 400);

      // Brightness scaling (full on-time when the option is compiled out).
      brightness = 8'd128;
      wait_latches(5, 2000);
      brightness = 8'd0;
      wait_latches(5, 2000);
      brightness = 8'd255;

      // Asynchronous reset in the middle of an on-time.
      wait_latches(1, 400);
      repeat (10) @(negedge clk); #1;
      check("lit_before_reset", int'(led_blank), 0);
      #1 resetn = 1'b0;
      #1;
      check("async_rst_blank", int'(led_blank), 1);
      check("async_rst_latch", int'(led_latch), 0);
      check("async_rst_addr", int'(led_addr), 0);
      check("async_rst_start", int'(shift_start), 0);
      enable = 1'b0;
      repeat (3) @(negedge clk); #1;
      restart_cnt++;
      resetn = 1'b1;
      repeat (2) @(negedge clk); #1;
      snap_start = start_cnt; snap_latch = latch_cnt;
      spur_done = 1'b1;
      @(negedge clk); #1;
      spur_done = 1'b0;
      repeat (20) @(negedge clk); #1;
      check("spurious_done_no_latch", latch_cnt - snap_latch, 0);
      check("spurious_done_no_start", start_cnt - snap_start, 0);
      check("spurious_done_blank", int'(led_blank), 1);
      enable = 1'b1;
      wait_latches(3, 1200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
